// File: rtl/alu_exec.sv
// alu_exec -- single-issue execute ALU with a multi-cycle shift-add multiplier.
//
// Ports:
//   clk_i       sole clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     request strobe, only looked at while idle
//   ctrl_i      4-bit operation code
//   src1_i      operand 1 (rs)
//   src2_i      operand 2 (rt / immediate)
//   shamt_i     shift amount for SLL
//   busy_o      high while a multiply is iterating
//   done_o      one-cycle completion pulse
//   result_o    registered result, held until the next completion
//   zero_o      registered (result_o == 0)
//   overflow_o  registered signed overflow of ADD/SUB
//   illegal_o   last completed op had an undefined code
//
// Single-cycle ops complete at the accept edge. MUL captures its operands at
// the accept edge and runs 32 shift-add steps, completing on the 32nd edge.
module alu_exec (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [4:0]  shamt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        overflow_o,
    output logic        illegal_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRLV = 4'b0110;
    localparam logic [3:0] OP_LUI  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_ovf;
    logic        r_ill;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_res;
    logic        w_ovf;
    logic        w_ill;
    logic [31:0] w_acc_next;

    assign w_sum  = src1_i + src2_i;
    assign w_diff = src1_i - src2_i;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        w_res = 32'h0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (ctrl_i)
            OP_AND:  w_res = src1_i & src2_i;
            OP_OR:   w_res = src1_i | src2_i;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (src1_i[31] == src2_i[31]) && (w_sum[31] != src1_i[31]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (src1_i[31] != src2_i[31]) && (w_diff[31] != src1_i[31]);
            end
            OP_SLT:  w_res = {31'h0, $signed(src1_i) < $signed(src2_i)};
            OP_SLL:  w_res = src2_i << shamt_i;
            OP_SRLV: w_res = src2_i >> src1_i[4:0];
            OP_LUI:  w_res = {src2_i[15:0], 16'h0000};
            OP_JMP:  w_res = src1_i;
            OP_MUL:  w_res = 32'h0;  // handled by the iterative path
            default: w_ill = 1'b1;
        endcase
    end

    // One shift-add step; only the low 32 bits matter, so signedness is moot.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_mcand  <= 32'h0;
            r_mplier <= 32'h0;
            r_acc    <= 32'h0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'h0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (ctrl_i == OP_MUL) begin
                            r_state  <= S_MUL;
                            r_busy   <= 1'b1;
                            r_mcand  <= src1_i;
                            r_mplier <= src2_i;
                            r_acc    <= 32'h0;
                            r_cnt    <= 5'd0;
                        end else begin
                            r_result <= w_res;
                            r_zero   <= (w_res == 32'h0);
                            r_ovf    <= w_ovf;
                            r_ill    <= w_ill;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // start_i is deliberately not looked at here.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= w_acc_next;
                        r_zero   <= (w_acc_next == 32'h0);
                        r_ovf    <= 1'b0;
                        r_ill    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign result_o   = r_result;
    assign zero_o     = r_zero;
    assign overflow_o = r_ovf;
    assign illegal_o  = r_ill;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: table of single-cycle vectors issued back-to-back, plus
// hand-written multiply sequences (plain, start held, abort by reset).
// Expected completions go into a queue when issued and are popped on done_o.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] src1, src2;
    logic [4:0]  shamt;
    logic        busy_o, done_o, zero_o, overflow_o, illegal_o;
    logic [31:0] result_o;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ctrl_i     (ctrl),
        .src1_i     (src1),
        .src2_i     (src2),
        .shamt_i    (shamt),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o),
        .illegal_o  (illegal_o)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } exp_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    exp_t sbq [$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every done_o pulse must match the oldest issued op.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done_o === 1'b1) begin
            n_done++;
            if (sbq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1, expected 0 (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("result",   result_o,           e.res);
                chk("zero",     {31'h0, zero_o},     {31'h0, (e.res == 32'h0)});
                chk("overflow", {31'h0, overflow_o}, {31'h0, e.ovf});
                chk("illegal",  {31'h0, illegal_o},  {31'h0, e.ill});
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   {31'h0, busy_o},     32'h0);
        chk({tag, "_done"},   {31'h0, done_o},     32'h0);
        chk({tag, "_result"}, result_o,            32'h0);
        chk({tag, "_zero"},   {31'h0, zero_o},     32'h1);
        chk({tag, "_ovf"},    {31'h0, overflow_o}, 32'h0);
        chk({tag, "_ill"},    {31'h0, illegal_o},  32'h0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
        chk({tag, "_pending"}, sbq.size(), 32'h0);
        sbq.delete();
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input bit abort);
        exp_t e;
        int   d0, nb;
        bit   got;
        @(negedge clk);
        start = 1'b1; ctrl = 4'b1001; src1 = a; src2 = b;
        if (!abort) begin
            e.res = a * b; e.ovf = 1'b0; e.ill = 1'b0;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        // Operands are captured; scramble inputs to prove they are ignored.
        if (!hold) start = 1'b0;
        ctrl = 4'b0010; src1 = $urandom; src2 = $urandom;
        d0 = n_done;
        nb = 0;
        got = 1'b0;
        if (abort) begin
            repeat (9) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk_reset("abort");
            rst = 1'b0; start = 1'b0;
            repeat (40) @(negedge clk);
            chk("abort_no_done", n_done - d0, 32'h0);
            chk("abort_no_pending", sbq.size(), 32'h0);
        end else begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done_o) begin got = 1'b1; break; end
                if (busy_o) nb++;
            end
            start = 1'b0;
            chk("mul_done_seen", {31'h0, got}, 32'h1);
            chk("mul_busy_cycles", nb, 32);
            chk("mul_busy_at_done", {31'h0, busy_o}, 32'h0);
            repeat (3) @(negedge clk);
            chk("mul_done_count", n_done - d0, 32'h1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{4'h3, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
        vecs[3]  = '{4'h5, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
        vecs[4]  = '{4'h6, 32'h00000024, 32'h80000000, 5'd0,  32'h08000000, 1'b0, 1'b0};
        vecs[5]  = '{4'h7, 32'h00000000, 32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0, 1'b0};
        vecs[6]  = '{4'hA, 32'hDEADBEEF, 32'h12345678, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0};
        vecs[7]  = '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
        vecs[8]  = '{4'h1, 32'h0F0F0000, 32'h000000F0, 5'd0,  32'h0F0F00F0, 1'b0, 1'b0};
        vecs[9]  = '{4'h3, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[10] = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[11] = '{4'h4, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b0, 1'b1};
        vecs[13] = '{4'h8, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b1};
        vecs[14] = '{4'h2, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b0};
        vecs[15] = '{4'h3, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0};
        vecs[16] = '{4'h6, 32'h0000003F, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; ctrl = 4'h0; src1 = 32'h0; src2 = 32'h0; shamt = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");

        // Back-to-back issue: one new op each cycle, first one right out of reset.
        for (int i = 0; i < NV; i++) begin
            exp_t e;
            if (i != 0) @(negedge clk);
            rst = 1'b0;
            start = 1'b1; ctrl = vecs[i].ctrl; src1 = vecs[i].a; src2 = vecs[i].b;
            shamt = vecs[i].sh;
            e.res = vecs[i].res; e.ovf = vecs[i].ovf; e.ill = vecs[i].ill;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        drain("table");
        repeat (3) @(negedge clk);
        chk("hold_result", result_o, vecs[NV-1].res);
        chk("hold_done", {31'h0, done_o}, 32'h0);

        run_mul(32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0);
        chk("mul_neg_result", result_o, 32'hFFFFFFEB);
        run_mul(32'd1234, 32'd5678, 1'b1, 1'b0);
        run_mul(32'h12345678, 32'h9ABCDEF1, 1'b0, 1'b0);
        run_mul(32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_mul(32'h0000BEEF, 32'h00001234, 1'b0, 1'b1);

        // Recovery after the aborted multiply.
        begin
            exp_t e;
            @(negedge clk);
            start = 1'b1; ctrl = 4'h2; src1 = 32'h00000010; src2 = 32'h00000020;
            e.res = 32'h00000030; e.ovf = 1'b0; e.ill = 1'b0;
            sbq.push_back(e);
            @(negedge clk);
            start = 1'b0;
            drain("recover");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
